// File: rtl/demux_1x4_reg.sv
// demux_1x4_reg: registered 1-to-4 demultiplexer with valid/ready handshake.
// Each output channel owns a one-entry holding register. The target channel
// comes from sel, or from an internal round-robin pointer when DEMUX_RR_EN is
// defined (the port list is the same in both builds).
module demux_1x4_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   sel,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
  output logic         valid_a,
  output logic         valid_b,
  output logic         valid_c,
  output logic         valid_d,
  input  logic         ready_a,
  input  logic         ready_b,
  input  logic         ready_c,
  input  logic         ready_d,
  output logic [1:0]   cur_sel,
  output logic         busy
);

  logic [W-1:0] data_q [4];
  logic [3:0]   vld_q;
  logic [3:0]   vld_d;
  logic [3:0]   load;
  logic [3:0]   rdy;
  logic         accept;

  assign rdy = {ready_d, ready_c, ready_b, ready_a};

`ifdef DEMUX_RR_EN
  logic [1:0] ptr_q;
  logic       unused_sel;

  assign unused_sel = ^sel;

  // Pointer moves only on an accepted beat, so a full target stalls the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (accept) begin
      ptr_q <= ptr_q + 2'd1;
    end
  end

  assign cur_sel = ptr_q;
`else
  assign cur_sel = sel;
`endif

  // Target is free when empty or being drained this cycle.
  assign in_ready = ~vld_q[cur_sel] | rdy[cur_sel];
  assign accept   = in_valid & in_ready;

  // Per-channel load strobes and next valid: load wins over a same-cycle drain.
  always_comb begin
    load  = 4'b0000;
    vld_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      load[i]  = accept && (cur_sel == 2'(i));
      vld_d[i] = load[i] | (vld_q[i] & ~rdy[i]);
    end
  end

  // Valid flags; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 4'b0000;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Holding registers keep their contents after a drain until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  assign out_a   = data_q[0];
  assign out_b   = data_q[1];
  assign out_c   = data_q[2];
  assign out_d   = data_q[3];
  assign valid_a = vld_q[0];
  assign valid_b = vld_q[1];
  assign valid_c = vld_q[2];
  assign valid_d = vld_q[3];
  assign busy    = |vld_q;

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Testbench for demux_1x4_reg: vector table plus per-channel scoreboard,
// followed by a hand-written mid-stream reset sequence.
module tb_demux_1x4_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic       ready_a, ready_b, ready_c, ready_d;
  logic [1:0] cur_sel;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic [3:0] q_c[$];
  logic [3:0] q_d[$];

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [3:0] data;
    logic [3:0] rdy;
    logic       exp_rdy;
    logic [1:0] exp_cs;
    logic [3:0] exp_vld;
    logic       ck;
    logic [1:0] ck_ch;
    logic [3:0] ck_data;
  } vec_t;

  vec_t tbl[$];

  demux_1x4_reg #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
    .valid_a(valid_a), .valid_b(valid_b), .valid_c(valid_c), .valid_d(valid_d),
    .ready_a(ready_a), .ready_b(ready_b), .ready_c(ready_c), .ready_d(ready_d),
    .cur_sel(cur_sel), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Upstream protocol: a stalled beat keeps sel, data and valid stable.
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (in_valid && $stable(sel) && $stable(in_data)));

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] s, input logic [3:0] d,
                     input logic [3:0] r, input logic er, input logic [1:0] ecs,
                     input logic [3:0] ev, input logic ck, input logic [1:0] cch,
                     input logic [3:0] cd);
    vec_t t;
    t.v = v; t.sel = s; t.data = d; t.rdy = r; t.exp_rdy = er; t.exp_cs = ecs;
    t.exp_vld = ev; t.ck = ck; t.ck_ch = cch; t.ck_data = cd;
    tbl.push_back(t);
  endtask

  task automatic sb_push(input logic [1:0] ch, input logic [3:0] d);
    case (ch)
      2'd0: q_a.push_back(d);
      2'd1: q_b.push_back(d);
      2'd2: q_c.push_back(d);
      default: q_d.push_back(d);
    endcase
  endtask

  function automatic logic [3:0] out_of(input logic [1:0] ch);
    case (ch)
      2'd0: return out_a;
      2'd1: return out_b;
      2'd2: return out_c;
      default: return out_d;
    endcase
  endfunction

  task automatic sb_pop(input string name, input int sz, input logic [3:0] front,
                        input logic [3:0] got);
    n_cmp++;
    if (sz == 0) begin
      n_err++;
      $display("FAIL %s: unexpected beat %0h, none required", name, got);
    end else if (got !== front) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, front);
    end
  endtask

  // A beat leaves a channel on any cycle with valid and ready both high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_a && ready_a) begin
        sb_pop("sb_a", q_a.size(), (q_a.size() > 0) ? q_a[0] : 4'h0, out_a);
        if (q_a.size() > 0) void'(q_a.pop_front());
      end
      if (valid_b && ready_b) begin
        sb_pop("sb_b", q_b.size(), (q_b.size() > 0) ? q_b[0] : 4'h0, out_b);
        if (q_b.size() > 0) void'(q_b.pop_front());
      end
      if (valid_c && ready_c) begin
        sb_pop("sb_c", q_c.size(), (q_c.size() > 0) ? q_c[0] : 4'h0, out_c);
        if (q_c.size() > 0) void'(q_c.pop_front());
      end
      if (valid_d && ready_d) begin
        sb_pop("sb_d", q_d.size(), (q_d.size() > 0) ? q_d[0] : 4'h0, out_d);
        if (q_d.size() > 0) void'(q_d.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] r);
    in_valid = v; sel = s; in_data = d;
    {ready_d, ready_c, ready_b, ready_a} = r;
  endtask

  initial begin
`ifdef DEMUX_RR_EN
    // sel tied to 11; pointer chooses the channel.
    for (int i = 1; i <= 5; i++)
      add(1, 2'd3, 4'(i), 4'b1111, 1, 2'((i - 1) % 4), 4'(1 << ((i - 1) % 4)),
          1, 2'((i - 1) % 4), 4'(i));
    add(1, 2'd3, 4'd6,  4'b1111, 1, 2'd1, 4'b0010, 1, 2'd1, 4'd6);
    add(1, 2'd3, 4'd7,  4'b1011, 1, 2'd2, 4'b0100, 1, 2'd2, 4'd7);
    add(1, 2'd3, 4'd8,  4'b1011, 1, 2'd3, 4'b1100, 1, 2'd3, 4'd8);
    add(1, 2'd3, 4'd9,  4'b1011, 1, 2'd0, 4'b0101, 1, 2'd0, 4'd9);
    add(1, 2'd3, 4'd10, 4'b1011, 1, 2'd1, 4'b0110, 1, 2'd1, 4'd10);
    add(1, 2'd3, 4'd11, 4'b1011, 0, 2'd2, 4'b0100, 1, 2'd2, 4'd7);
    add(1, 2'd3, 4'd11, 4'b1011, 0, 2'd2, 4'b0100, 1, 2'd2, 4'd7);
    add(1, 2'd3, 4'd11, 4'b1111, 1, 2'd2, 4'b0100, 1, 2'd2, 4'd11);
    add(0, 2'd3, 4'd0,  4'b1111, 1, 2'd3, 4'b0000, 0, 2'd0, 4'd0);
`else
    // One beat to each channel, ready high everywhere.
    for (int i = 0; i < 4; i++)
      add(1, 2'(i), 4'(i + 1), 4'b1111, 1, 2'(i), 4'(1 << i), 1, 2'(i), 4'(i + 1));
    add(0, 2'd0, 4'd0, 4'b1111, 1, 2'd0, 4'b0000, 0, 2'd0, 4'd0);
    // Channel b backpressured; c stays independent; then b load+drain together.
    add(1, 2'd1, 4'd5, 4'b1101, 1, 2'd1, 4'b0010, 1, 2'd1, 4'd5);
    add(1, 2'd2, 4'd7, 4'b1101, 1, 2'd2, 4'b0110, 1, 2'd2, 4'd7);
    add(1, 2'd1, 4'd6, 4'b1101, 0, 2'd1, 4'b0010, 1, 2'd1, 4'd5);
    add(1, 2'd1, 4'd6, 4'b1101, 0, 2'd1, 4'b0010, 1, 2'd1, 4'd5);
    add(1, 2'd1, 4'd6, 4'b1111, 1, 2'd1, 4'b0010, 1, 2'd1, 4'd6);
    add(0, 2'd0, 4'd0, 4'b1111, 1, 2'd0, 4'b0000, 0, 2'd0, 4'd0);
    // Full-rate stream into channel a.
    for (int i = 1; i <= 8; i++)
      add(1, 2'd0, 4'(i), 4'b1111, 1, 2'd0, 4'b0001, 1, 2'd0, 4'(i));
    add(0, 2'd0, 4'd0, 4'b1111, 1, 2'd0, 4'b0000, 0, 2'd0, 4'd0);
`endif

    // Reset held for two cycles.
    rst_n = 1'b0;
    drive(0, 2'd0, 4'd0, 4'b1111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst valid", {4'b0, valid_d, valid_c, valid_b, valid_a}, 8'h00);
    check("rst out", {out_b, out_a}, 8'h00);
    check("rst out_cd", {out_d, out_c}, 8'h00);
    check("rst in_ready", {7'b0, in_ready}, 8'h01);
    check("rst busy", {7'b0, busy}, 8'h00);
    check("rst cur_sel", {6'b0, cur_sel}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      if (tbl[i].v && tbl[i].exp_rdy) sb_push(tbl[i].exp_cs, tbl[i].data);
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), {7'b0, in_ready}, {7'b0, tbl[i].exp_rdy});
      check($sformatf("vec%0d cur_sel", i), {6'b0, cur_sel}, {6'b0, tbl[i].exp_cs});
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", i), {4'b0, valid_d, valid_c, valid_b, valid_a},
            {4'b0, tbl[i].exp_vld});
      check($sformatf("vec%0d busy", i), {7'b0, busy}, {7'b0, |tbl[i].exp_vld});
      if (tbl[i].ck)
        check($sformatf("vec%0d out%0d", i, tbl[i].ck_ch), {4'b0, out_of(tbl[i].ck_ch)},
              {4'b0, tbl[i].ck_data});
    end

    // Mid-stream reset: fill d then a with ready low, then reset asynchronously.
    drive(1, 2'd3, 4'd9, 4'b0000);
    sb_push(2'd3, 4'd9);
    @(posedge clk); #1;
    drive(1, 2'd0, 4'd10, 4'b0000);
    sb_push(2'd0, 4'd10);
    @(posedge clk); #1;
    drive(0, 2'd0, 4'd0, 4'b0000);
    check("mid full a/d", {4'b0, valid_d, valid_c, valid_b, valid_a}, 8'h09);
    check("mid busy", {7'b0, busy}, 8'h01);
    check("mid held", {out_d, out_a}, {4'd9, 4'd10});
    #2 rst_n = 1'b0;
    #1;
    check("async valid", {4'b0, valid_d, valid_c, valid_b, valid_a}, 8'h00);
    check("async busy", {7'b0, busy}, 8'h00);
    check("async out", {out_d, out_a}, 8'h00);
    check("async cur_sel", {6'b0, cur_sel}, 8'h00);
    check("async in_ready", {7'b0, in_ready}, 8'h01);
    q_a.delete();
    q_d.delete();
    drive(1, 2'd0, 4'd11, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 2'd0, 4'd0, 4'b0000);
    @(posedge clk); #1;
    check("post rst valid", {4'b0, valid_d, valid_c, valid_b, valid_a}, 8'h00);
    check("post rst busy", {7'b0, busy}, 8'h00);
    drive(0, 2'd0, 4'd0, 4'b1111);
    repeat (3) @(posedge clk);
    #1;
    check("sb drained", 8'(q_a.size() + q_b.size() + q_c.size() + q_d.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
